// File: rtl/switch_ring_sched.sv
// Phase sequencer and injection arbiter for the 4-port switch ring.
// Alternates CHECK/SHIFT rounds and grants one requester per SHIFT (round-robin with starvation escalation).
module switch_ring_sched #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             slot_free,
  input  logic [3:0]       req,
  output logic             phase_check,
  output logic             phase_shift,
  output logic [3:0]       gnt,
  output logic [3:0]       starve,
  output logic [CNT_W-1:0] gnt_total
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [7:0]       LIMIT   = 8'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_phase_check;
  logic             r_phase_shift;
  logic [3:0]       r_gnt;
  logic [3:0]       r_starve;
  logic [CNT_W-1:0] r_gnt_total;
  logic [1:0]       r_ptr;
  logic [7:0]       r_wait [4];

  logic [3:0]       w_gnt;
  logic [1:0]       w_idx;
  logic [3:0]       w_starved_req;
  logic [7:0]       w_wait_nxt [4];

  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Rotate so that bit 0 of the result is v[p].
  function automatic logic [3:0] rotate(input logic [3:0] v, input logic [1:0] p);
    logic [3:0] r;
    case (p)
      2'd0:    r = v;
      2'd1:    r = {v[0], v[3:1]};
      2'd2:    r = {v[1:0], v[3:2]};
      2'd3:    r = {v[2:0], v[3]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Grant selection: starved requesters first (lowest index), then round-robin from ptr.
  always_comb begin
    w_starved_req = r_starve & req;
    w_idx         = 2'd0;
    w_gnt         = 4'b0000;
    if (slot_free && (req != 4'b0000)) begin
      if (w_starved_req != 4'b0000) begin
        w_idx = first_set(w_starved_req);
      end else begin
        w_idx = r_ptr + first_set(rotate(req, r_ptr));
      end
      w_gnt = 4'b0001 << w_idx;
    end else begin
      w_gnt = 4'b0000;
    end
  end

  // Next wait count per port, applied only on the CHECK->SHIFT edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_wait_nxt[i] = 8'd0;
      if (req[i] && !w_gnt[i]) begin
        w_wait_nxt[i] = (r_wait[i] < LIMIT) ? (r_wait[i] + 8'd1) : LIMIT;
      end else begin
        w_wait_nxt[i] = 8'd0;
      end
    end
  end

  // Phase FSM with registered phase decodes, grant, starvation and grant counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_phase_check <= 1'b0;
      r_phase_shift <= 1'b0;
      r_gnt         <= 4'b0000;
      r_starve      <= 4'b0000;
      r_gnt_total   <= {CNT_W{1'b0}};
      r_ptr         <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_wait[i] <= 8'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_phase_shift <= 1'b0;
          r_gnt         <= 4'b0000;
          if (run) begin
            r_state       <= ST_CHECK;
            r_phase_check <= 1'b1;
          end else begin
            r_state       <= ST_IDLE;
            r_phase_check <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_state       <= ST_SHIFT;
          r_phase_check <= 1'b0;
          r_phase_shift <= 1'b1;
          r_gnt         <= w_gnt;
          for (int i = 0; i < 4; i++) begin
            r_wait[i]   <= w_wait_nxt[i];
            r_starve[i] <= (w_wait_nxt[i] == LIMIT);
          end
          if (w_gnt != 4'b0000) begin
            r_ptr <= w_idx + 2'd1;
            if (r_gnt_total != CNT_MAX) begin
              r_gnt_total <= r_gnt_total + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_SHIFT: begin
          r_phase_shift <= 1'b0;
          r_gnt         <= 4'b0000;
          if (run) begin
            r_state       <= ST_CHECK;
            r_phase_check <= 1'b1;
          end else begin
            r_state       <= ST_IDLE;
            r_phase_check <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_phase_check <= 1'b0;
          r_phase_shift <= 1'b0;
          r_gnt         <= 4'b0000;
        end
      endcase
    end
  end

  assign phase_check = r_phase_check;
  assign phase_shift = r_phase_shift;
  assign gnt         = r_gnt;
  assign starve      = r_starve;
  assign gnt_total   = r_gnt_total;

endmodule

// File: tb/tb_switch_ring_sched.sv
// Directed-vector bench for switch_ring_sched: table of per-cycle stimulus/expectations
// plus hand-written sequences for asynchronous reset and counter saturation.
module tb_switch_ring_sched;

  logic        clk;
  logic        reset;
  logic        run;
  logic        slot_free;
  logic [3:0]  req;
  logic        phase_check;
  logic        phase_shift;
  logic [3:0]  gnt;
  logic [3:0]  starve;
  logic [15:0] gnt_total;

  int checks;
  int failures;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        slf;
    logic [3:0]  req;
    logic        e_chk;
    logic        e_shf;
    logic [3:0]  e_gnt;
    logic [3:0]  e_stv;
    logic [15:0] e_tot;
  } vec_t;

  vec_t vecs[$];

  switch_ring_sched #(.STARVE_LIMIT(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .slot_free   (slot_free),
    .req         (req),
    .phase_check (phase_check),
    .phase_shift (phase_shift),
    .gnt         (gnt),
    .starve      (starve),
    .gnt_total   (gnt_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic rn, input logic slf, input logic [3:0] rq,
                              input logic ec, input logic es, input logic [3:0] eg,
                              input logic [3:0] ev, input logic [15:0] et);
    vec_t v;
    v.rst = rst; v.run = rn; v.slf = slf; v.req = rq;
    v.e_chk = ec; v.e_shf = es; v.e_gnt = eg; v.e_stv = ev; v.e_tot = et;
    vecs.push_back(v);
  endfunction

  task automatic check_all(input string tag, input logic ec, input logic es, input logic [3:0] eg,
                           input logic [3:0] ev, input logic [15:0] et);
    check({tag, "_chk"}, {15'd0, phase_check}, {15'd0, ec});
    check({tag, "_shf"}, {15'd0, phase_shift}, {15'd0, es});
    check({tag, "_gnt"}, {12'd0, gnt}, {12'd0, eg});
    check({tag, "_stv"}, {12'd0, starve}, {12'd0, ev});
    check({tag, "_tot"}, gnt_total, et);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    run = 1'b0;
    slot_free = 1'b0;
    req = 4'b0000;

    // round-robin over all four ports
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd0);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, 16'd1);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd1);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0000, 16'd2);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd2);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0000, 16'd3);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd3);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'b0000, 16'd4);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd4);
    add(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, 16'd5);
    // sparse requesters from ptr=0; CHECK-entry rows carry junk req/slot_free
    add(1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd0);
    add(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 4'b0010, 4'b0000, 16'd1);
    add(1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd1);
    add(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 4'b1000, 4'b0000, 16'd2);
    add(1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd2);
    add(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 4'b0010, 4'b0000, 16'd3);
    // no slot for 8 rounds: ports 0 and 2 starve
    for (int k = 1; k <= 8; k++) begin
      add(1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd3);
      add(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 4'b0000, (k == 8) ? 4'b0101 : 4'b0000, 16'd3);
    end
    add(1'b0, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0101, 16'd3);
    add(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, 4'b0001, 4'b0100, 16'd4);
    add(1'b0, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0100, 16'd4);
    add(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, 4'b0100, 4'b0000, 16'd5);
    // run drops during CHECK: SHIFT still grants, then IDLE for 3 cycles
    add(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd5);
    add(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 16'd6);
    add(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd6);
    add(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd6);
    add(1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd6);
    add(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd6);
    // slot free but nobody requesting: no grant, no count
    add(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 16'd6);
    add(1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd6);
    add(1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0000, 16'd7);

    #12;
    check_all("reset", 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      run = vecs[i].run;
      slot_free = vecs[i].slf;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_chk, vecs[i].e_shf, vecs[i].e_gnt, vecs[i].e_stv, vecs[i].e_tot);
    end

    // asynchronous reset while gnt=0010 is live in SHIFT
    #1;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;
    slot_free = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    #1;
    check_all("post_rst_chk", 1'b1, 1'b0, 4'b0000, 4'b0000, 16'd0);
    @(posedge clk);
    #1;
    check_all("post_rst_shf", 1'b0, 1'b1, 4'b0001, 4'b0000, 16'd1);

    // saturation of the grant counter from 2^16-2
    force dut.r_gnt_total = 16'hFFFE;
    #1;
    release dut.r_gnt_total;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_chk", r), {15'd0, phase_check}, 16'd1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_gnt", r), {12'd0, gnt}, {12'd0, 4'b0010 << r});
      check($sformatf("sat%0d_tot", r), gnt_total, 16'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
